// File: rtl/mod_counter_n.sv
// Modulo-N up/down counter with optional prescaler, wrap/saturate boundary
// handling, zero-latency terminal count and a sticky overflow flag.
module mod_counter_n #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("mod_counter_n: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("mod_counter_n: PRESCALE must be >= 1");
    end

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_load_val;
    logic             r_ovf;
    logic             w_tick;
    logic             w_busy;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_bound;

    // clr and load both suppress counting and restart the prescaler phase
    assign w_busy     = clr | load;
    assign w_load_val = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
    assign w_at_max   = (r_q == MAX_VAL);
    assign w_at_zero  = (r_q == ZERO_VAL);
    assign w_bound    = up ? w_at_max : w_at_zero;

    if (PRESCALE == 1) begin : g_no_pre
        assign w_tick = en & ~w_busy;
    end else begin : g_pre
        localparam int             PW       = $clog2(PRESCALE);
        localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
        localparam logic [PW-1:0]  PRE_ZERO = {PW{1'b0}};
        logic [PW-1:0] r_pre;

        assign w_tick = en & ~w_busy & (r_pre == PRE_LAST);

        // Prescaler phase: frozen when en is low, restarted by clr/load
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pre <= PRE_ZERO;
            end else if (w_busy) begin
                r_pre <= PRE_ZERO;
            end else if (en) begin
                r_pre <= w_tick ? PRE_ZERO : r_pre + PW'(1);
            end else begin
                r_pre <= r_pre;
            end
        end
    end

    // Terminal count is combinational so a chained stage can use it as its enable
    assign tc = w_tick & w_bound;

    // Next count on a step; arithmetic stays within 0..MODULUS-1
    always_comb begin
        w_q_next = r_q;
        if (w_tick) begin
            if (up) begin
                if (w_at_max) begin
                    w_q_next = (SATURATE != 0) ? MAX_VAL : ZERO_VAL;
                end else begin
                    w_q_next = r_q + WIDTH'(1);
                end
            end else begin
                if (w_at_zero) begin
                    w_q_next = (SATURATE != 0) ? ZERO_VAL : MAX_VAL;
                end else begin
                    w_q_next = r_q - WIDTH'(1);
                end
            end
        end else begin
            w_q_next = r_q;
        end
    end

    // Count and sticky overflow; priority rst > clr > load > step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= ZERO_VAL;
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_q   <= ZERO_VAL;
            r_ovf <= 1'b0;
        end else if (load) begin
            r_q   <= w_load_val;
            r_ovf <= r_ovf;
        end else begin
            r_q   <= w_q_next;
            r_ovf <= r_ovf | tc;
        end
    end

    assign Q   = r_q;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_mod_counter_n.sv
// Bench for mod_counter_n: four parameterisations driven by shared stimulus and
// compared every cycle against a modulo-arithmetic reference model.
module tb_mod_counter_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
    logic [3:0] lv = 4'd0;

    logic [3:0] q_dut   [4];
    logic       tc_dut  [4];
    logic       ovf_dut [4];

    int n_tests = 0;
    int n_fail  = 0;

    // Per-instance configuration: modulus, prescale, saturate
    int m_mod [4] = '{16, 10, 10, 16};
    int m_pre [4] = '{1, 1, 1, 3};
    int m_sat [4] = '{0, 0, 1, 0};

    // Reference state: count value, enabled-clock phase, sticky overflow
    int mq   [4];
    int mph  [4];
    bit movf [4];

    always #5 clk = ~clk;

    mod_counter_n #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .SATURATE(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv), .Q(q_dut[0]), .tc(tc_dut[0]), .ovf(ovf_dut[0]));
    mod_counter_n #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv), .Q(q_dut[1]), .tc(tc_dut[1]), .ovf(ovf_dut[1]));
    mod_counter_n #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv), .Q(q_dut[2]), .tc(tc_dut[2]), .ovf(ovf_dut[2]));
    mod_counter_n #(.WIDTH(4), .MODULUS(16), .PRESCALE(3), .SATURATE(0)) u3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv), .Q(q_dut[3]), .tc(tc_dut[3]), .ovf(ovf_dut[3]));

    function automatic bit model_tc(int k);
        bit stepping;
        bit at_edge;
        stepping = en && !clr && !load && ((mph[k] + 1) % m_pre[k] == 0);
        at_edge  = up ? (mq[k] == m_mod[k] - 1) : (mq[k] == 0);
        return stepping && at_edge;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mq[k] = 0; mph[k] = 0; movf[k] = 1'b0;
        end
    endtask

    // Advance the model by one clock edge using the inputs presented at that edge
    task automatic model_update();
        for (int k = 0; k < 4; k++) begin
            if (rst || clr) begin
                mq[k] = 0; mph[k] = 0; movf[k] = 1'b0;
            end else if (load) begin
                mq[k] = (int'(lv) >= m_mod[k]) ? m_mod[k] - 1 : int'(lv);
                mph[k] = 0;
            end else if (en) begin
                mph[k] = (mph[k] + 1) % m_pre[k];
                if (mph[k] == 0) begin
                    if (up && mq[k] == m_mod[k] - 1) begin
                        movf[k] = 1'b1;
                        mq[k] = m_sat[k] ? mq[k] : 0;
                    end else if (!up && mq[k] == 0) begin
                        movf[k] = 1'b1;
                        mq[k] = m_sat[k] ? 0 : m_mod[k] - 1;
                    end else begin
                        mq[k] = (mq[k] + (up ? 1 : m_mod[k] - 1)) % m_mod[k];
                    end
                end
            end
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; up = 1'b1;
        model_reset();
        clk_step();
        clk_step();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({q_dut[k], ovf_dut[k]} !== {4'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset u%0d: Q=%0d ovf=%b, expected Q=0 ovf=0", k, q_dut[k], ovf_dut[k]);
            end
        end
        rst = 1'b0;
        clk_step();
    endtask

    task automatic test_count_up();
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if ({q_dut[0], tc_dut[0], ovf_dut[0]} !== {4'(i % 16), (i == 15), (i >= 16)}) begin
                n_fail++;
                $display("FAIL count_up cycle %0d: Q=%0d tc=%b ovf=%b, expected Q=%0d tc=%b ovf=%b",
                         i, q_dut[0], tc_dut[0], ovf_dut[0], i % 16, (i == 15), (i >= 16));
            end
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if ({q_dut[k], tc_dut[k], ovf_dut[k]} !== {4'(mq[k]), model_tc(k), movf[k]}) begin
                    n_fail++;
                    $display("FAIL count_up_model u%0d: Q=%0d tc=%b ovf=%b, expected Q=%0d tc=%b ovf=%b",
                             k, q_dut[k], tc_dut[k], ovf_dut[k], mq[k], model_tc(k), movf[k]);
                end
            end
            clk_step();
        end
    endtask

    task automatic test_down_wrap();
        int seq [5] = '{2, 1, 0, 9, 8};
        en = 1'b0; clr = 1'b1;
        clk_step();
        clr = 1'b0; load = 1'b1; lv = 4'd2; up = 1'b0;
        clk_step();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if ({q_dut[1], tc_dut[1]} !== {4'(seq[i]), (i == 2)}) begin
                n_fail++;
                $display("FAIL down_wrap step %0d: Q=%0d tc=%b, expected Q=%0d tc=%b",
                         i, q_dut[1], tc_dut[1], seq[i], (i == 2));
            end
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if ({q_dut[k], tc_dut[k], ovf_dut[k]} !== {4'(mq[k]), model_tc(k), movf[k]}) begin
                    n_fail++;
                    $display("FAIL down_wrap_model u%0d: Q=%0d tc=%b ovf=%b, expected Q=%0d tc=%b ovf=%b",
                             k, q_dut[k], tc_dut[k], ovf_dut[k], mq[k], model_tc(k), movf[k]);
                end
            end
            clk_step();
        end
    endtask

    task automatic test_saturate();
        int seq [4] = '{8, 9, 9, 9};
        en = 1'b0; clr = 1'b1;
        clk_step();
        clr = 1'b0; load = 1'b1; lv = 4'd8; up = 1'b1;
        clk_step();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if ({q_dut[2], ovf_dut[2]} !== {4'(seq[i]), (i >= 2)}) begin
                n_fail++;
                $display("FAIL saturate step %0d: Q=%0d ovf=%b, expected Q=%0d ovf=%b",
                         i, q_dut[2], ovf_dut[2], seq[i], (i >= 2));
            end
            clk_step();
        end
        en = 1'b0; clr = 1'b1;
        clk_step();
        clr = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({q_dut[2], ovf_dut[2]} !== {4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL saturate_clr: Q=%0d ovf=%b, expected Q=0 ovf=0", q_dut[2], ovf_dut[2]);
        end
        clk_step();
    endtask

    task automatic test_prescale();
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            // en drops after 10 enabled clocks, leaving the prescaler mid-phase
            en = (i < 10);
            @(negedge clk);
            n_tests++;
            if (q_dut[3] !== 4'((i < 10) ? i / 3 : 3)) begin
                n_fail++;
                $display("FAIL prescale clock %0d: Q=%0d, expected Q=%0d", i, q_dut[3], (i < 10) ? i / 3 : 3);
            end
            clk_step();
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({q_dut[3], tc_dut[3]} !== {4'((i < 2) ? 3 : 4), 1'b0}) begin
                n_fail++;
                $display("FAIL prescale_resume %0d: Q=%0d tc=%b, expected Q=%0d tc=0",
                         i, q_dut[3], tc_dut[3], (i < 2) ? 3 : 4);
            end
            n_tests++;
            if (q_dut[3] !== 4'(mq[3])) begin
                n_fail++;
                $display("FAIL prescale_model %0d: Q=%0d, expected Q=%0d", i, q_dut[3], mq[3]);
            end
            clk_step();
        end
    endtask

    task automatic test_priority();
        int exp_q [4];
        en = 1'b0; load = 1'b1; lv = 4'd15;
        clk_step();
        for (int p = 0; p < 3; p++) begin
            en = 1'b1; up = 1'b1;
            clr  = (p == 0);
            load = 1'b1;
            lv   = (p == 2) ? 4'd12 : 4'd5;
            for (int k = 0; k < 4; k++) begin
                exp_q[k] = (p == 0) ? 0 : ((int'(lv) >= m_mod[k]) ? m_mod[k] - 1 : int'(lv));
            end
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if (tc_dut[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL priority_tc p%0d u%0d: tc=%b, expected tc=0", p, k, tc_dut[k]);
                end
            end
            clk_step();
            clr = 1'b0; load = 1'b0; en = 1'b0;
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if (q_dut[k] !== 4'(exp_q[k]) || q_dut[k] !== 4'(mq[k])) begin
                    n_fail++;
                    $display("FAIL priority p%0d u%0d: Q=%0d, expected Q=%0d", p, k, q_dut[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        en = 1'b0; clr = 1'b1;
        clk_step();
        clr = 1'b0; load = 1'b1; lv = 4'd15; up = 1'b1;
        clk_step();
        load = 1'b0; en = 1'b1;
        clk_step();
        en = 1'b0; load = 1'b1; lv = 4'd7;
        clk_step();
        load = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({q_dut[0], ovf_dut[0]} !== {4'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL async_setup: Q=%0d ovf=%b, expected Q=7 ovf=1", q_dut[0], ovf_dut[0]);
        end
        @(posedge clk);
        model_update();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if ({q_dut[k], ovf_dut[k]} !== {4'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL async_rst u%0d: Q=%0d ovf=%b, expected Q=0 ovf=0", k, q_dut[k], ovf_dut[k]);
            end
        end
        #1;
        rst = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (q_dut[0] !== 4'(i) || q_dut[3] !== 4'(mq[3])) begin
                n_fail++;
                $display("FAIL async_resume %0d: Q0=%0d Q3=%0d, expected Q0=%0d Q3=%0d",
                         i, q_dut[0], q_dut[3], i, mq[3]);
            end
            clk_step();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1) == 1;
            clr  = ($urandom_range(0, 31) == 0);
            load = ($urandom_range(0, 15) == 0);
            lv   = 4'($urandom_range(0, 15));
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if ({q_dut[k], tc_dut[k], ovf_dut[k]} !== {4'(mq[k]), model_tc(k), movf[k]}) begin
                    n_fail++;
                    $display("FAIL random cycle %0d u%0d: Q=%0d tc=%b ovf=%b, expected Q=%0d tc=%b ovf=%b",
                             i, k, q_dut[k], tc_dut[k], ovf_dut[k], mq[k], model_tc(k), movf[k]);
                end
            end
            clk_step();
        end
        en = 1'b0; clr = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_down_wrap();
        test_saturate();
        test_prescale();
        test_priority();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
